sccb_slave: RTL and testbench

SCCB responder modelling the OV7670 register interface: decodes SIOC/SIOD traffic from our SCCB master, acknowledges its device address, commits 3-phase writes into an internal 256x8 register file and answers 2-phase-write + 2-phase-read sequences. Sits on the far end of the camera-init bus for loopback and bench self-checking, and doubles as a synthesizable camera stand-in on boards without a sensor.

---
 rtl/sccb_slave_if.sv | 23 ++
 rtl/sccb_slave.sv | 177 +++++++++++++++++
 tb/tb_sccb_slave.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_slave_if.sv
// SCCB responder bus bundle: SIOC/SIOD from the master, open-drain pull-down,
// register-commit strobe and the debug read port of the register file.
interface sccb_slave_if;
  logic       i_sioc;
  logic       i_siod;
  logic       o_siod_oe;
  logic       o_wr_pulse;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_busy;
  logic [7:0] i_dbg_addr;
  logic [7:0] o_dbg_data;

  modport slave (
    input  i_sioc, i_siod, i_dbg_addr,
    output o_siod_oe, o_wr_pulse, o_wr_addr, o_wr_data, o_busy, o_dbg_data
  );

  modport master (
    output i_sioc, i_siod, i_dbg_addr,
    input  o_siod_oe, o_wr_pulse, o_wr_addr, o_wr_data, o_busy, o_dbg_data
  );
endinterface

// File: rtl/sccb_slave.sv
// OV7670-style SCCB responder: oversamples SIOC/SIOD, acks its device address,
// commits 3-phase writes into a 256x8 register file and serves 2-phase reads.
module sccb_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic        i_clk,
  input  logic        i_rst,
  sccb_slave_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
  } state_t;

  logic [1:0] sioc_sync_q, siod_sync_q;
  logic       sioc_prev_q, siod_prev_q;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] sub_addr_q, sub_addr_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regfile [256];

  logic sioc_s, siod_s, sioc_rise, sioc_fall, start_c, stop_c;
  logic [7:0] rx_byte, rd_byte;

  assign sioc_s    = sioc_sync_q[1];
  assign siod_s    = siod_sync_q[1];
  assign sioc_rise = sioc_s & ~sioc_prev_q;
  assign sioc_fall = ~sioc_s & sioc_prev_q;
  // SIOC must be stably high across both samples, so a simultaneous SIOC edge wins
  assign start_c   = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
  assign stop_c    = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;
  assign rx_byte   = {shift_q, siod_s};
  assign rd_byte   = regfile[sub_addr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    sub_addr_d = sub_addr_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (start_c) begin
      state_d = DEV;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else if (stop_c) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        DEV, SUB, WDATA: begin
          if (sioc_rise) begin
            shift_d = rx_byte[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == DEV) begin
                rw_d    = rx_byte[0];
                state_d = (rx_byte[7:1] == DEV_ADDR) ? DEV_ACK : IGNORE;
              end else if (state_q == SUB) begin
                sub_addr_d = rx_byte;
                state_d    = SUB_ACK;
              end else begin
                wr_pulse_d = 1'b1;
                wr_addr_d  = sub_addr_q;
                wr_data_d  = rx_byte;
                state_d    = WDATA_ACK;
              end
            end
          end
        end
        DEV_ACK, SUB_ACK, WDATA_ACK: begin
          // oe itself marks the ACK phase: first fall pulls low, second fall ends it
          if (sioc_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 3'd0;
              if (state_q == SUB_ACK) begin
                state_d = WDATA;
              end else if (state_q == WDATA_ACK) begin
                state_d = IGNORE;
              end else if (!rw_q) begin
                state_d = SUB;
              end else begin
                state_d = RDATA;
                oe_d    = ~rd_byte[7];
                tx_d    = {rd_byte[6:0], 1'b0};
              end
            end
          end
        end
        RDATA: begin
          if (sioc_fall) begin
            if (cnt_q == 3'd7) begin
              oe_d    = 1'b0;
              cnt_d   = 3'd0;
              state_d = RDATA_NA;
            end else begin
              oe_d  = ~tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        RDATA_NA: begin
          if (sioc_rise) state_d = IGNORE;
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    sioc_sync_q <= {sioc_sync_q[0], bus.i_sioc};
    siod_sync_q <= {siod_sync_q[0], bus.i_siod};
    sioc_prev_q <= sioc_s;
    siod_prev_q <= siod_s;
    if (i_rst) begin
      // idle bus is high; preloading 1s keeps reset release from faking an edge
      sioc_sync_q <= 2'b11;
      siod_sync_q <= 2'b11;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      tx_q        <= 8'd0;
      sub_addr_q  <= 8'd0;
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      sub_addr_q <= sub_addr_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Commit from the registered strobe so the debug port shows the new value one cycle later
  always_ff @(posedge i_clk) begin
    if (wr_pulse_q) regfile[wr_addr_q] <= wr_data_q;
  end

  assign bus.o_siod_oe  = oe_q;
  assign bus.o_wr_pulse = wr_pulse_q;
  assign bus.o_wr_addr  = wr_addr_q;
  assign bus.o_wr_data  = wr_data_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_dbg_data = regfile[bus.i_dbg_addr];
endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bit-banged SCCB master on an open-drain SIOD model.
module tb_sccb_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] dbg_addr = 8'd0;

  sccb_slave_if bus ();
  assign bus.i_sioc     = m_scl;
  assign bus.i_siod     = m_sda & ~bus.o_siod_oe;
  assign bus.i_dbg_addr = dbg_addr;

  sccb_slave #(.DEV_ADDR(7'h21)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int q_clk  = 20;

  int         pulse_cnt   = 0;
  int         multi_pulse = 0;
  int         oe_cnt      = 0;
  logic       prev_pulse  = 1'b0;
  logic [7:0] cap_addr[$];
  logic [7:0] cap_data[$];

  always @(negedge clk) begin
    if (bus.o_wr_pulse === 1'b1) begin
      pulse_cnt++;
      cap_addr.push_back(bus.o_wr_addr);
      cap_data.push_back(bus.o_wr_data);
      if (prev_pulse) multi_pulse++;
    end
    prev_pulse = (bus.o_wr_pulse === 1'b1);
    if (bus.o_siod_oe === 1'b1) oe_cnt++;
  end

  task automatic wq();
    repeat (q_clk) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    m_sda = b; wq();
    m_scl = 1'b1; wq();
    seen = bus.i_siod; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, output logic na_oe);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    na_oe = bus.o_siod_oe; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_txn(input logic [7:0] addr, input logic [7:0] data, output int acks);
    logic a;
    acks = 0;
    bus_start();
    send_byte(8'h42, a); acks += int'(a);
    send_byte(addr, a);  acks += int'(a);
    send_byte(data, a);  acks += int'(a);
    bus_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_siod_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", bus.o_siod_oe); end
    checks++; if (bus.o_wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", bus.o_wr_pulse); end
    checks++; if (bus.o_wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", bus.o_wr_addr); end
    checks++; if (bus.o_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", bus.o_wr_data); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_write();
    int   base = pulse_cnt;
    int   acks = 0;
    logic a;
    bus_start();
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL write_busy_start: got %b want 1", bus.o_busy); end
    send_byte(8'h42, a); acks += int'(a);
    send_byte(8'h12, a); acks += int'(a);
    send_byte(8'h80, a); acks += int'(a);
    bus_stop();
    checks++; if (acks != 3) begin errors++; $display("FAIL write_acks: got %0d want 3", acks); end
    checks++; if (pulse_cnt - base != 1) begin errors++; $display("FAIL write_pulses: got %0d want 1", pulse_cnt - base); end
    checks++; if (cap_addr.size() <= base || cap_addr[base] !== 8'h12) begin errors++; $display("FAIL write_addr: got %h want 12", bus.o_wr_addr); end
    checks++; if (cap_data.size() <= base || cap_data[base] !== 8'h80) begin errors++; $display("FAIL write_data: got %h want 80", bus.o_wr_data); end
    checks++; if (bus.o_wr_addr !== 8'h12 || bus.o_wr_data !== 8'h80) begin errors++; $display("FAIL write_held: got %h/%h want 12/80", bus.o_wr_addr, bus.o_wr_data); end
    dbg_addr = 8'h12; @(negedge clk);
    checks++; if (bus.o_dbg_data !== 8'h80) begin errors++; $display("FAIL write_dbg: got %h want 80", bus.o_dbg_data); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_read();
    int         base;
    int         acks = 0;
    logic       a, na_oe;
    logic [7:0] d;
    write_txn(8'h3A, 8'h04, acks);
    base = pulse_cnt;
    bus_start();
    send_byte(8'h42, a); acks += int'(a);
    send_byte(8'h3A, a); acks += int'(a);
    bus_stop();
    bus_start();
    send_byte(8'h43, a); acks += int'(a);
    read_byte(d, na_oe);
    bus_stop();
    checks++; if (acks != 6) begin errors++; $display("FAIL read_acks: got %0d want 6", acks); end
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL read_data: got %h want 04", d); end
    checks++; if (na_oe !== 1'b0) begin errors++; $display("FAIL read_na_release: got oe=%b want 0", na_oe); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL read_busy: got %b want 0", bus.o_busy); end
    checks++; if (pulse_cnt != base) begin errors++; $display("FAIL read_no_pulse: got %0d want 0", pulse_cnt - base); end
  endtask

  task automatic test_wrong_dev();
    int   base  = pulse_cnt;
    int   oe0   = oe_cnt;
    int   acks  = 0;
    logic a;
    bus_start();
    send_byte(8'h60, a); acks += int'(a);
    send_byte(8'h12, a); acks += int'(a);
    send_byte(8'h55, a); acks += int'(a);
    bus_stop();
    checks++; if (acks != 0) begin errors++; $display("FAIL wrongdev_acks: got %0d want 0", acks); end
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL wrongdev_oe: got %0d oe cycles want 0", oe_cnt - oe0); end
    checks++; if (pulse_cnt != base) begin errors++; $display("FAIL wrongdev_pulse: got %0d want 0", pulse_cnt - base); end
    dbg_addr = 8'h12; @(negedge clk);
    checks++; if (bus.o_dbg_data !== 8'h80) begin errors++; $display("FAIL wrongdev_reg: got %h want 80", bus.o_dbg_data); end
  endtask

  task automatic test_repeated_start();
    int         base;
    int         acks = 0;
    logic       a, na_oe;
    logic [7:0] d;
    write_txn(8'h11, 8'h5C, acks);
    base = pulse_cnt;
    acks = 0;
    bus_start();
    send_byte(8'h42, a); acks += int'(a);
    send_byte(8'h11, a); acks += int'(a);
    bus_rstart();
    send_byte(8'h43, a); acks += int'(a);
    read_byte(d, na_oe);
    bus_stop();
    checks++; if (acks != 3) begin errors++; $display("FAIL rstart_acks: got %0d want 3", acks); end
    checks++; if (d !== 8'h5C) begin errors++; $display("FAIL rstart_data: got %h want 5c", d); end
    checks++; if (na_oe !== 1'b0) begin errors++; $display("FAIL rstart_na_release: got oe=%b want 0", na_oe); end
    checks++; if (pulse_cnt != base) begin errors++; $display("FAIL rstart_no_pulse: got %0d want 0", pulse_cnt - base); end
  endtask

  task automatic test_reset_mid();
    int   base;
    int   acks = 0;
    logic s;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(8'h42 >> i, s);
    m_sda = 1'b1; wq();
    checks++; if (bus.o_siod_oe !== 1'b1) begin errors++; $display("FAIL rstmid_ack_driven: got %b want 1", bus.o_siod_oe); end
    rst = 1'b1; @(negedge clk);
    checks++; if (bus.o_siod_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe: got %b want 0", bus.o_siod_oe); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.o_busy); end
    rst = 1'b0; wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
    bus_stop();
    base = pulse_cnt;
    write_txn(8'h01, 8'hAA, acks);
    checks++; if (acks != 3) begin errors++; $display("FAIL rstmid_acks: got %0d want 3", acks); end
    checks++; if (pulse_cnt - base != 1) begin errors++; $display("FAIL rstmid_pulses: got %0d want 1", pulse_cnt - base); end
    checks++; if (bus.o_wr_addr !== 8'h01 || bus.o_wr_data !== 8'hAA) begin errors++; $display("FAIL rstmid_write: got %h/%h want 01/aa", bus.o_wr_addr, bus.o_wr_data); end
    dbg_addr = 8'h01; @(negedge clk);
    checks++; if (bus.o_dbg_data !== 8'hAA) begin errors++; $display("FAIL rstmid_dbg: got %h want aa", bus.o_dbg_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rom_a [60];
    logic [7:0] rom_d [60];
    int base = pulse_cnt;
    int total_acks = 0;
    int acks;
    for (int i = 0; i < 60; i++) begin
      rom_a[i] = 8'(i * 3 + 1);
      rom_d[i] = 8'(i * 37 + 5) ^ 8'h5A;
    end
    q_clk = 5;
    for (int i = 0; i < 60; i++) begin
      write_txn(rom_a[i], rom_d[i], acks);
      total_acks += acks;
    end
    q_clk = 20;
    checks++; if (total_acks != 180) begin errors++; $display("FAIL b2b_acks: got %0d want 180", total_acks); end
    checks++; if (pulse_cnt - base != 60) begin errors++; $display("FAIL b2b_pulses: got %0d want 60", pulse_cnt - base); end
    checks++; if (multi_pulse != 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses want 0", multi_pulse); end
    for (int i = 0; i < 60; i++) begin
      if (base + i < cap_addr.size()) begin
        checks++;
        if (cap_addr[base + i] !== rom_a[i] || cap_data[base + i] !== rom_d[i]) begin
          errors++;
          $display("FAIL b2b_entry%0d: got %h/%h want %h/%h", i, cap_addr[base + i], cap_data[base + i], rom_a[i], rom_d[i]);
        end
      end
    end
    dbg_addr = rom_a[59]; @(negedge clk);
    checks++; if (bus.o_dbg_data !== rom_d[59]) begin errors++; $display("FAIL b2b_dbg: got %h want %h", bus.o_dbg_data, rom_d[59]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_dev();
    test_repeated_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
